// File: rtl/branch_resolve.sv
// branch_resolve: single-stage registered RV32 branch/jump resolution with valid/ready output
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready request handshake (in_ready is combinational)
//   op, funct3        00 branch (funct3 selects condition), 01 JAL, 10 JALR, 11 reserved
//   rs1_val, rs2_val  source operands
//   pc, imm           instruction address, sign-extended immediate
//   pred_taken/target front-end prediction
//   flush             drop held result and block capture this cycle
//   out_valid/ready   result handshake
//   taken, target     resolved direction and next PC
//   link              pc+4 for rd writeback
//   mispredict        resolved next PC differs from predicted next PC
//   illegal           reserved op or funct3 010/011
//   misalign          taken target not word aligned (only with BRU_MISALIGN_EN)
//
// Build option: define BRU_MISALIGN_EN to enable misaligned-target detection.
module branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            mispredict,
    output logic            illegal,
    output logic            misalign
);
    logic            eq_c, lt_c, ltu_c, cond_c, ill_c, taken_c, mis_c, mp_c;
    logic [XLEN-1:0] link_c, btgt_c, jtgt_c, tgt_c, next_c, pnext_c;

    always_comb begin
        eq_c    = rs1_val == rs2_val;
        lt_c    = $signed(rs1_val) < $signed(rs2_val);
        ltu_c   = rs1_val < rs2_val;
        // funct3[2:1] picks the comparison, funct3[0] inverts it
        cond_c  = (funct3[2] ? (funct3[1] ? ltu_c : lt_c) : eq_c) ^ funct3[0];
        ill_c   = (op == 2'b11) || (op == 2'b00 && funct3[2:1] == 2'b01);
        taken_c = !ill_c && (op != 2'b00 || cond_c);
        link_c  = pc + 32'd4;
        btgt_c  = pc + imm;
        jtgt_c  = rs1_val + imm;
        tgt_c   = (op == 2'b10) ? {jtgt_c[XLEN-1:1], 1'b0} : btgt_c;
        next_c  = taken_c ? tgt_c : link_c;
        pnext_c = pred_taken ? pred_target : link_c;
`ifdef BRU_MISALIGN_EN
        mis_c   = taken_c && tgt_c[1];
`else
        mis_c   = 1'b0;
`endif
        // illegal and misaligned instructions go to the trap path, never to redirect
        mp_c    = (next_c != pnext_c) && !ill_c && !mis_c;
    end

    assign in_ready = rst_n && !flush && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            taken      <= 1'b0;
            target     <= '0;
            link       <= '0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
            misalign   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid  <= 1'b1;
            taken      <= taken_c;
            target     <= next_c;
            link       <= link_c;
            mispredict <= mp_c;
            illegal    <= ill_c;
            misalign   <= mis_c;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed + model-checked bench for branch_resolve
module tb_branch_resolve;
    logic        clk = 0, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, pc, imm, pred_target, target, link;
    logic        pred_taken, taken, mispredict, illegal, misalign;
    int          passed = 0, total = 0;
    logic        started = 0;

    typedef struct packed {
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lnk;
        logic        mp;
        logic        ill;
        logic        mis;
    } res_t;

    res_t m_res;
    logic m_valid, m_zero;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .pc(pc), .imm(imm), .pred_taken(pred_taken), .pred_target(pred_target),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .target(target), .link(link), .mispredict(mispredict),
        .illegal(illegal), .misalign(misalign)
    );

    function automatic res_t resolve(logic [1:0] o, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] p, logic [31:0] i, logic pt, logic [31:0] ptg);
        res_t r;
        logic [31:0] nxt, pnx;
        r = '0;
        r.lnk = p + 4;
        r.tgt = p + i;
        case (o)
            2'd0: case (f)
                3'd0: r.tk = (a == b);
                3'd1: r.tk = (a != b);
                3'd4: r.tk = ($signed(a) < $signed(b));
                3'd5: r.tk = ($signed(a) >= $signed(b));
                3'd6: r.tk = (a < b);
                3'd7: r.tk = (a >= b);
                default: r.ill = 1;
            endcase
            2'd1: r.tk = 1;
            2'd2: begin r.tk = 1; r.tgt = (a + i) & 32'hFFFF_FFFE; end
            default: r.ill = 1;
        endcase
`ifdef BRU_MISALIGN_EN
        r.mis = r.tk && (r.tgt % 4 >= 2);
`endif
        nxt = r.tk ? r.tgt : r.lnk;
        pnx = pt ? ptg : r.lnk;
        r.mp = (nxt != pnx) && !r.ill && !r.mis;
        r.tgt = nxt;
        return r;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 0; m_res <= '0; m_zero <= 1;
        end else if (flush) begin
            m_valid <= 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1; m_zero <= 0;
            m_res <= resolve(op, funct3, rs1_val, rs2_val, pc, imm, pred_taken, pred_target);
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) if (started) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, rst_n && !flush && (!m_valid || out_ready)});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid || m_zero) begin
            check("taken", {31'd0, taken}, {31'd0, m_res.tk});
            check("target", target, m_res.tgt);
            check("link", link, m_res.lnk);
            check("mispredict", {31'd0, mispredict}, {31'd0, m_res.mp});
            check("illegal", {31'd0, illegal}, {31'd0, m_res.ill});
            check("misalign", {31'd0, misalign}, {31'd0, m_res.mis});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(logic [1:0] o, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                       logic [31:0] p, logic [31:0] i, logic pt, logic [31:0] ptg);
        op = o; funct3 = f; rs1_val = a; rs2_val = b; pc = p; imm = i;
        pred_taken = pt; pred_target = ptg; in_valid = 1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
        op = 0; funct3 = 0; rs1_val = 0; rs2_val = 0; pc = 0; imm = 0;
        pred_taken = 0; pred_target = 0;
        repeat (2) step();
        started = 1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1; out_ready = 1;

        req(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 0);
        step();
        check("blt_valid", {31'd0, out_valid}, 32'd1);
        check("blt_taken", {31'd0, taken}, 32'd1);
        check("blt_target", target, 32'h120);
        check("blt_mp", {31'd0, mispredict}, 32'd1);

        req(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 0, 0);
        step();
        check("bltu_taken", {31'd0, taken}, 32'd0);
        check("bltu_target", target, 32'h104);
        check("bltu_mp", {31'd0, mispredict}, 32'd0);

        req(2'd2, 3'd0, 32'h1001, 32'd0, 32'h200, 32'h4, 1, 32'h1004);
        step();
        check("jalr_target", target, 32'h1004);
        check("jalr_link", link, 32'h204);
        check("jalr_mp", {31'd0, mispredict}, 32'd0);

        req(2'd0, 3'd3, 32'd7, 32'd7, 32'h280, 32'h40, 1, 32'h2C0);
        step();
        check("ill_illegal", {31'd0, illegal}, 32'd1);
        check("ill_taken", {31'd0, taken}, 32'd0);
        check("ill_mp", {31'd0, mispredict}, 32'd0);

        out_ready = 0;
        req(2'd0, 3'd0, 32'd5, 32'd5, 32'h300, 32'h40, 1, 32'h340);
        repeat (3) begin
            step();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_target", target, 32'h284);
            check("bp_hold_illegal", {31'd0, illegal}, 32'd1);
        end
        out_ready = 1;
        step();
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_target", target, 32'h340);
        check("bp_next_mp", {31'd0, mispredict}, 32'd0);

        req(2'd0, 3'd1, 32'd1, 32'd2, 32'h400, 32'h10, 0, 0);
        flush = 1;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 0; in_valid = 0;
        step();
        check("flush_nocap", {31'd0, out_valid}, 32'd0);

        req(2'd1, 3'd0, 32'd0, 32'd0, 32'h500, 32'h100, 0, 0);
        step();
        out_ready = 0; in_valid = 0;
        step();
        rst_n = 0;
        step();
        check("rstm_valid", {31'd0, out_valid}, 32'd0);
        check("rstm_taken", {31'd0, taken}, 32'd0);
        check("rstm_target", target, 32'd0);
        check("rstm_link", link, 32'd0);
        check("rstm_mp", {31'd0, mispredict}, 32'd0);
        rst_n = 1; out_ready = 1;

        req(2'd1, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1, 32'h4);
        step();
        check("wrap_target", target, 32'h4);
        check("wrap_link", link, 32'h0);
        check("wrap_mp", {31'd0, mispredict}, 32'd0);

        req(2'd0, 3'd5, 32'h8000_0000, 32'd0, 32'h600, 32'h80, 1, 32'h680);
        step();
        check("bge_taken", {31'd0, taken}, 32'd0);
        check("bge_mp", {31'd0, mispredict}, 32'd1);

        req(2'd0, 3'd7, 32'h8000_0000, 32'd0, 32'h600, 32'h80, 1, 32'h680);
        step();
        check("bgeu_taken", {31'd0, taken}, 32'd1);
        check("bgeu_target", target, 32'h680);

        req(2'd1, 3'd0, 32'd0, 32'd0, 32'h0, 32'h6, 0, 0);
        step();
        check("mis_target", target, 32'h6);
`ifdef BRU_MISALIGN_EN
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_mp", {31'd0, mispredict}, 32'd0);
`else
        check("mis_flag", {31'd0, misalign}, 32'd0);
        check("mis_mp", {31'd0, mispredict}, 32'd1);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [31:0] vals [4];
            vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
            req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)],
                {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 32'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 64)));
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (2) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
